// File: rtl/alu_pkg.sv
// Shared definitions for the ALU/register-file pipeline: opcodes, flag bit
// positions and the flag-setting classification.
package alu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_MOV = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  // Ops that replace alu_flags on writeback; all others keep the old flags.
  function automatic logic op_sets_flags(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier. One multiplier bit is consumed per cycle;
// the last bit is folded in combinationally so the full product is on prod_o
// in the DATA_WIDTH-th active cycle, flagged by done_o. Operands must be held
// stable from start_i until done_o.
module alu_mul_iter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [2*DATA_WIDTH-1:0] prod_o
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic                    busy_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2*DATA_WIDTH-1:0] acc_q, acc_cur, pp;
  logic                    active;

  // Current partial sum: a fresh start ignores leftover accumulator state.
  always_comb begin
    active  = start_i || busy_q;
    cnt_d   = start_i ? '0 : cnt_q;
    acc_cur = start_i ? '0 : acc_q;
    pp      = b_i[cnt_d] ? ({{DATA_WIDTH{1'b0}}, a_i} << cnt_d) : '0;
    prod_o  = acc_cur + pp;
    done_o  = active && (cnt_d == CNT_W'(DATA_WIDTH - 1));
  end

  // Iteration control; reset abandons any product in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (active) begin
      busy_q <= !done_o;
      cnt_q  <= cnt_d + 1'b1;
    end
  end

  // Accumulator needs no reset: every product starts from zero via start_i.
  always_ff @(posedge clk_i) begin
    if (active) acc_q <= prod_o;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/alu_regfile_pipe.sv
// Two-stage ALU/register-file pipeline: accept+operand read (with forwarding
// from the EX result) then execute+writeback. Optional feature macro:
// ALU_MUL_EN enables the iterative MUL (op A); without it op A is illegal.
module alu_regfile_pipe
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int SHAMT_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic [ADDR_WIDTH-1:0] in_rs1,
  input  logic [ADDR_WIDTH-1:0] in_rs2,
  input  logic [DATA_WIDTH-1:0] in_imm,
  output logic                  wb_valid,
  output logic [ADDR_WIDTH-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [3:0]            alu_flags,
  output logic                  illegal_op,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int NREGS = 2 ** ADDR_WIDTH;
  localparam int MSB   = DATA_WIDTH - 1;

  logic [DATA_WIDTH-1:0] rf_q [NREGS];

  logic                  ex_vld_q, ex_vld_d;
  logic [3:0]            ex_op_q;
  logic [ADDR_WIDTH-1:0] ex_rd_q;
  logic [DATA_WIDTH-1:0] ex_a_q, ex_b_q, ex_imm_q;
  logic [DATA_WIDTH-1:0] opa_d, opb_d;

  logic                  wb_valid_q, illegal_q;
  logic [ADDR_WIDTH-1:0] wb_rd_q;
  logic [DATA_WIDTH-1:0] wb_data_q, dbg_data_q;
  logic [3:0]            flags_q;

  logic                  accept, ex_legal, ex_writes, ex_done, wr_en, fwd_ok;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH:0]   sum_w, diff_w, shl_w, shr_w;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                  alu_c, alu_v;
  logic [3:0]            alu_flg;

  function automatic logic op_legal(input logic [3:0] op);
`ifdef ALU_MUL_EN
    return op <= OP_MUL;
`else
    return op <= OP_MOV;
`endif
  endfunction

`ifdef ALU_MUL_EN
  logic                    mul_start, mul_busy, mul_done;
  logic [2*DATA_WIDTH-1:0] mul_prod;

  assign mul_start = ex_vld_q && (ex_op_q == OP_MUL) && !mul_busy;

  alu_mul_iter #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk_i   (clk),
    .rst_i   (reset),
    .start_i (mul_start),
    .a_i     (ex_a_q),
    .b_i     (ex_b_q),
    .busy_o  (mul_busy),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  // A MUL holds EX for its whole run, so nothing new may enter behind it.
  assign in_ready = !(ex_vld_q && (ex_op_q == OP_MUL));
  assign ex_done  = ex_vld_q && ((ex_op_q != OP_MUL) || mul_done);
`else
  assign in_ready = 1'b1;
  assign ex_done  = ex_vld_q;
`endif

  assign accept    = in_valid && in_ready;
  assign ex_legal  = op_legal(ex_op_q);
  assign ex_writes = ex_legal && (ex_op_q != OP_NOP);
  assign wr_en     = ex_done && ex_writes;
  assign fwd_ok    = ex_vld_q && ex_writes;
  assign shamt     = ex_b_q[SHAMT_WIDTH-1:0];

  // Operand select with EX-result forwarding and EX occupancy next state.
  always_comb begin
    opa_d    = (fwd_ok && (in_rs1 == ex_rd_q)) ? alu_res : rf_q[in_rs1];
    opb_d    = (fwd_ok && (in_rs2 == ex_rd_q)) ? alu_res : rf_q[in_rs2];
    ex_vld_d = accept ? 1'b1 : (ex_done ? 1'b0 : ex_vld_q);
  end

  // ALU: result plus candidate {V,C,N,Z}; ADD/SUB carry out of bit DATA_WIDTH.
  always_comb begin
    sum_w   = {1'b0, ex_a_q} + {1'b0, ex_b_q};
    diff_w  = {1'b0, ex_a_q} - {1'b0, ex_b_q};
    shl_w   = {1'b0, ex_a_q} << shamt;
    shr_w   = {ex_a_q, 1'b0} >> shamt;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ex_op_q)
      OP_LDI: alu_res = ex_imm_q;
      OP_ADD: begin
        alu_res = sum_w[MSB:0];
        alu_c   = sum_w[DATA_WIDTH];
        alu_v   = (ex_a_q[MSB] == ex_b_q[MSB]) && (sum_w[MSB] != ex_a_q[MSB]);
      end
      OP_SUB: begin
        alu_res = diff_w[MSB:0];
        alu_c   = diff_w[DATA_WIDTH];
        alu_v   = (ex_a_q[MSB] != ex_b_q[MSB]) && (diff_w[MSB] != ex_a_q[MSB]);
      end
      OP_AND: alu_res = ex_a_q & ex_b_q;
      OP_OR:  alu_res = ex_a_q | ex_b_q;
      OP_XOR: alu_res = ex_a_q ^ ex_b_q;
      OP_SHL: begin
        alu_res = shl_w[MSB:0];
        alu_c   = shl_w[DATA_WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_w[DATA_WIDTH:1];
        alu_c   = shr_w[0];
      end
      OP_MOV: alu_res = ex_a_q;
`ifdef ALU_MUL_EN
      OP_MUL: begin
        alu_res = mul_prod[MSB:0];
        alu_c   = |mul_prod[2*DATA_WIDTH-1:DATA_WIDTH];
        alu_v   = alu_c;
      end
`endif
      default: alu_res = '0;
    endcase
    alu_flg         = '0;
    alu_flg[FLAG_Z] = (alu_res == '0);
    alu_flg[FLAG_N] = alu_res[MSB];
    alu_flg[FLAG_C] = alu_c;
    alu_flg[FLAG_V] = alu_v;
  end

  // EX occupancy; reset drops whatever is in flight.
  always_ff @(posedge clk) begin
    if (reset) ex_vld_q <= 1'b0;
    else       ex_vld_q <= ex_vld_d;
  end

  // ---- accept / operand read -> EX ----
  always_ff @(posedge clk) begin
    if (accept) begin
      ex_op_q  <= in_op;
      ex_rd_q  <= in_rd;
      ex_a_q   <= opa_d;
      ex_b_q   <= opb_d;
      ex_imm_q <= in_imm;
    end
  end

  // ---- EX -> writeback: register file, flags, wb/illegal pulses, debug read ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      flags_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      illegal_q  <= 1'b0;
      dbg_data_q <= '0;
    end else begin
      if (wr_en) begin
        rf_q[ex_rd_q] <= alu_res;
        wb_rd_q       <= ex_rd_q;
        wb_data_q     <= alu_res;
      end
      if (ex_done && ex_legal && op_sets_flags(ex_op_q)) flags_q <= alu_flg;
      wb_valid_q <= wr_en;
      illegal_q  <= ex_done && !ex_legal;
      dbg_data_q <= (wr_en && (ex_rd_q == dbg_addr)) ? alu_res : rf_q[dbg_addr];
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign alu_flags  = flags_q;
  assign illegal_op = illegal_q;
  assign dbg_data   = dbg_data_q;

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Directed bench for alu_regfile_pipe (default parameters). Follows the
// ALU_MUL_EN setting of the build for the MUL scenarios.
module tb_alu_regfile_pipe;

  localparam logic [3:0] NOP = 4'h0, LDI = 4'h1, ADD = 4'h2, SUB = 4'h3;
  localparam logic [3:0] XOR_ = 4'h6, SHL = 4'h7, SHR = 4'h8, MOV = 4'h9;
  localparam logic [3:0] MUL = 4'hA, ILL = 4'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = 4'h0;
  logic [3:0]  in_rd = 4'h0, in_rs1 = 4'h0, in_rs2 = 4'h0;
  logic [15:0] in_imm = 16'h0;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic [3:0]  alu_flags;
  logic        illegal_op;
  logic [3:0]  dbg_addr = 4'h0;
  logic [15:0] dbg_data;

  int total = 0;
  int bad = 0;

  alu_regfile_pipe dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .alu_flags  (alu_flags),
    .illegal_op (illegal_op),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and return 1ns after the edge that accepts it.
  task automatic send(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                      input logic [3:0] rs2, input logic [15:0] imm);
    int n;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    total++; if (!in_ready) begin bad++; $display("FAIL send_ready_timeout got=%0d cycles exp<50", n); end
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%h exp=0", wb_valid); end
    total++; if (wb_rd !== 4'h0) begin bad++; $display("FAIL rst_wb_rd got=%h exp=0", wb_rd); end
    total++; if (wb_data !== 16'h0) begin bad++; $display("FAIL rst_wb_data got=%h exp=0", wb_data); end
    total++; if (alu_flags !== 4'h0) begin bad++; $display("FAIL rst_flags got=%h exp=0", alu_flags); end
    total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL rst_illegal got=%h exp=0", illegal_op); end
    total++; if (dbg_data !== 16'h0) begin bad++; $display("FAIL rst_dbg got=%h exp=0", dbg_data); end
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%h exp=1", in_ready); end
  endtask

  task automatic test_ldi_dbg();
    send(LDI, 4'd1, 4'd0, 4'd0, 16'h0005);
    send(LDI, 4'd2, 4'd0, 4'd0, 16'h0003);
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL ldi1_wb_valid got=%h exp=1", wb_valid); end
    total++; if (wb_rd !== 4'd1) begin bad++; $display("FAIL ldi1_wb_rd got=%h exp=1", wb_rd); end
    total++; if (wb_data !== 16'h0005) begin bad++; $display("FAIL ldi1_wb_data got=%h exp=0005", wb_data); end
    dbg_addr = 4'd2;
    step();
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL ldi2_wb_valid got=%h exp=1", wb_valid); end
    total++; if (wb_rd !== 4'd2) begin bad++; $display("FAIL ldi2_wb_rd got=%h exp=2", wb_rd); end
    total++; if (wb_data !== 16'h0003) begin bad++; $display("FAIL ldi2_wb_data got=%h exp=0003", wb_data); end
    total++; if (dbg_data !== 16'h0003) begin bad++; $display("FAIL dbg_write_first got=%h exp=0003", dbg_data); end
    dbg_addr = 4'd1;
    step();
    total++; if (dbg_data !== 16'h0005) begin bad++; $display("FAIL dbg_r1 got=%h exp=0005", dbg_data); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL ldi_wb_idle got=%h exp=0", wb_valid); end
    total++; if (alu_flags !== 4'h0) begin bad++; $display("FAIL ldi_flags_held got=%h exp=0", alu_flags); end
  endtask

  task automatic test_forward();
    send(LDI, 4'd1, 4'd0, 4'd0, 16'h7FFF);
    send(ADD, 4'd3, 4'd1, 4'd1, 16'h0000);
    total++; if (wb_data !== 16'h7FFF) begin bad++; $display("FAIL fwd_ldi_data got=%h exp=7fff", wb_data); end
    step();
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL fwd_add_valid got=%h exp=1", wb_valid); end
    total++; if (wb_rd !== 4'd3) begin bad++; $display("FAIL fwd_add_rd got=%h exp=3", wb_rd); end
    total++; if (wb_data !== 16'hFFFE) begin bad++; $display("FAIL fwd_add_data got=%h exp=fffe", wb_data); end
    total++; if (alu_flags !== 4'hA) begin bad++; $display("FAIL fwd_add_flags got=%h exp=a", alu_flags); end
  endtask

  task automatic test_sub_mov();
    send(LDI, 4'd1, 4'd0, 4'd0, 16'h0005);
    send(SUB, 4'd4, 4'd2, 4'd1, 16'h0000);
    send(MOV, 4'd5, 4'd4, 4'd0, 16'h0000);
    total++; if (wb_rd !== 4'd4) begin bad++; $display("FAIL sub_rd got=%h exp=4", wb_rd); end
    total++; if (wb_data !== 16'hFFFE) begin bad++; $display("FAIL sub_data got=%h exp=fffe", wb_data); end
    total++; if (alu_flags !== 4'h6) begin bad++; $display("FAIL sub_flags got=%h exp=6", alu_flags); end
    step();
    total++; if (wb_rd !== 4'd5) begin bad++; $display("FAIL mov_rd got=%h exp=5", wb_rd); end
    total++; if (wb_data !== 16'hFFFE) begin bad++; $display("FAIL mov_data got=%h exp=fffe", wb_data); end
    total++; if (alu_flags !== 4'h6) begin bad++; $display("FAIL mov_flags_held got=%h exp=6", alu_flags); end
  endtask

  task automatic test_shift_illegal();
    send(LDI, 4'd1, 4'd0, 4'd0, 16'h8001);
    send(LDI, 4'd2, 4'd0, 4'd0, 16'h0001);
    send(SHL, 4'd6, 4'd1, 4'd2, 16'h0000);
    send(ILL, 4'd7, 4'd1, 4'd2, 16'h0000);
    total++; if (wb_data !== 16'h0002) begin bad++; $display("FAIL shl_data got=%h exp=0002", wb_data); end
    total++; if (alu_flags !== 4'h4) begin bad++; $display("FAIL shl_flags got=%h exp=4", alu_flags); end
    total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL shl_illegal got=%h exp=0", illegal_op); end
    step();
    total++; if (illegal_op !== 1'b1) begin bad++; $display("FAIL ill_pulse got=%h exp=1", illegal_op); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL ill_wb_valid got=%h exp=0", wb_valid); end
    total++; if (alu_flags !== 4'h4) begin bad++; $display("FAIL ill_flags_held got=%h exp=4", alu_flags); end
    step();
    total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL ill_pulse_end got=%h exp=0", illegal_op); end
    send(SHR, 4'd8, 4'd1, 4'd0, 16'h0000);
    step();
    total++; if (wb_data !== 16'h8001) begin bad++; $display("FAIL shr0_data got=%h exp=8001", wb_data); end
    total++; if (alu_flags !== 4'h2) begin bad++; $display("FAIL shr0_flags got=%h exp=2", alu_flags); end
    send(SHR, 4'd8, 4'd1, 4'd2, 16'h0000);
    step();
    total++; if (wb_data !== 16'h4000) begin bad++; $display("FAIL shr1_data got=%h exp=4000", wb_data); end
    total++; if (alu_flags !== 4'h4) begin bad++; $display("FAIL shr1_flags got=%h exp=4", alu_flags); end
    send(ADD, 4'd9, 4'd6, 4'd4, 16'h0000);
    step();
    total++; if (wb_data !== 16'h0000) begin bad++; $display("FAIL addc_data got=%h exp=0000", wb_data); end
    total++; if (alu_flags !== 4'h5) begin bad++; $display("FAIL addc_flags got=%h exp=5", alu_flags); end
    send(XOR_, 4'd10, 4'd1, 4'd2, 16'h0000);
    step();
    total++; if (wb_data !== 16'h8000) begin bad++; $display("FAIL xor_data got=%h exp=8000", wb_data); end
    total++; if (alu_flags !== 4'h2) begin bad++; $display("FAIL xor_flags got=%h exp=2", alu_flags); end
  endtask

  task automatic test_mul();
`ifdef ALU_MUL_EN
    int lo;
    send(LDI, 4'd14, 4'd0, 4'd0, 16'h1234);
    send(LDI, 4'd12, 4'd0, 4'd0, 16'h0100);
    send(LDI, 4'd13, 4'd0, 4'd0, 16'h0100);
    send(MUL, 4'd14, 4'd12, 4'd13, 16'h0000);
    lo = 0;
    while (!in_ready && lo < 40) begin lo++; step(); end
    total++; if (lo !== 16) begin bad++; $display("FAIL mul_stall got=%0d exp=16", lo); end
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL mul_wb_valid got=%h exp=1", wb_valid); end
    total++; if (wb_rd !== 4'd14) begin bad++; $display("FAIL mul_wb_rd got=%h exp=e", wb_rd); end
    total++; if (wb_data !== 16'h0000) begin bad++; $display("FAIL mul_data got=%h exp=0000", wb_data); end
    total++; if (alu_flags !== 4'hD) begin bad++; $display("FAIL mul_flags got=%h exp=d", alu_flags); end
    send(ADD, 4'd15, 4'd14, 4'd12, 16'h0000);
    step();
    total++; if (wb_data !== 16'h0100) begin bad++; $display("FAIL mul_next_add got=%h exp=0100", wb_data); end
    total++; if (alu_flags !== 4'h0) begin bad++; $display("FAIL mul_next_flags got=%h exp=0", alu_flags); end
    send(MUL, 4'd10, 4'd1, 4'd1, 16'h0000);
    lo = 0;
    while (!in_ready && lo < 40) begin lo++; step(); end
    total++; if (lo !== 16) begin bad++; $display("FAIL mul2_stall got=%0d exp=16", lo); end
    total++; if (wb_data !== 16'h0001) begin bad++; $display("FAIL mul2_data got=%h exp=0001", wb_data); end
    total++; if (alu_flags !== 4'hC) begin bad++; $display("FAIL mul2_flags got=%h exp=c", alu_flags); end
`else
    send(MUL, 4'd14, 4'd1, 4'd1, 16'h0000);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mul_off_ready got=%h exp=1", in_ready); end
    step();
    total++; if (illegal_op !== 1'b1) begin bad++; $display("FAIL mul_off_illegal got=%h exp=1", illegal_op); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL mul_off_wb got=%h exp=0", wb_valid); end
    dbg_addr = 4'd14;
    step();
    total++; if (dbg_data !== 16'h0000) begin bad++; $display("FAIL mul_off_r14 got=%h exp=0000", dbg_data); end
`endif
  endtask

  task automatic test_reset_mid();
`ifdef ALU_MUL_EN
    send(MUL, 4'd7, 4'd1, 4'd1, 16'h0000);
    repeat (3) step();
`else
    send(LDI, 4'd7, 4'd0, 4'd0, 16'h5555);
`endif
    reset = 1'b1;
    step();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rstmid_wb_in got=%h exp=0", wb_valid); end
    step();
    reset = 1'b0;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%h exp=1", in_ready); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rstmid_wb_after got=%h exp=0", wb_valid); end
    total++; if (alu_flags !== 4'h0) begin bad++; $display("FAIL rstmid_flags got=%h exp=0", alu_flags); end
    step();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rstmid_wb_late got=%h exp=0", wb_valid); end
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      step();
      total++; if (dbg_data !== 16'h0000) begin bad++; $display("FAIL rstmid_r%0d got=%h exp=0000", i, dbg_data); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_ldi_dbg();
    test_forward();
    test_sub_mov();
    test_shift_illegal();
    test_mul();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
